// File: rtl/alu_pkg.sv
// Shared types for the pipelined adder/subtractor: operation encoding and status flags.
package alu_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
  } addsub_flags_t;

  // A borrow-in on subtract becomes the inverted carry-in of A + ~B.
  function automatic logic eff_cin(input addsub_op_e op, input logic ci);
    return (op == OP_SUB) ? ~ci : ci;
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational W-bit ripple-carry adder slice; also reports the carry into its top bit.
module rca_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  // Ripple the carry bit by bit; c_msb_in keeps the carry entering bit W-1.
  always_comb begin
    logic c;
    c        = cin;
    c_msb_in = cin;
    s        = '0;
    for (int i = 0; i < W; i++) begin
      c_msb_in = c;
      s[i]     = a[i] ^ b[i] ^ c;
      c        = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage, global valid/ready stall.
module pipe_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V,
  output logic             Z
);

  localparam int CHUNK = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_add_sub: WIDTH must be divisible by STAGES and 1 <= STAGES <= WIDTH");
  end

  addsub_op_e                        op_s;
  logic                              advance_s;
  logic [WIDTH-1:0]                  beff_s;
  logic [STAGES-1:0]                 vld_q, vld_d;
  logic [STAGES-1:0][WIDTH-1:0]      a_q, b_q, s_q, s_d;
  logic [STAGES-1:0]                 c_q;
  logic [STAGES-1:0][CHUNK-1:0]      ca_s, cb_s, chunk_s;
  logic [STAGES-1:0]                 cc_s, co_s, cm_s;
  addsub_flags_t                     flags_q, flags_d;
  logic                              unused_s;

  assign op_s      = SUB ? OP_SUB : OP_ADD;
  assign beff_s    = (op_s == OP_SUB) ? ~B : B;
  assign advance_s = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = advance_s;
  // Last-stage skew copies only exist to keep the shift chain uniform.
  assign unused_s  = ^{a_q[STAGES-1], b_q[STAGES-1], c_q[STAGES-1]};

  // Select each stage's operand slice and carry: stage 0 from the ports, later stages from skew registers.
  always_comb begin
    ca_s[0] = A[CHUNK-1:0];
    cb_s[0] = beff_s[CHUNK-1:0];
    cc_s[0] = eff_cin(op_s, CI);
    for (int k = 1; k < STAGES; k++) begin
      ca_s[k] = a_q[k-1][k*CHUNK +: CHUNK];
      cb_s[k] = b_q[k-1][k*CHUNK +: CHUNK];
      cc_s[k] = c_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    rca_chunk #(.W(CHUNK)) u_chunk (
      .a        (ca_s[k]),
      .b        (cb_s[k]),
      .cin      (cc_s[k]),
      .s        (chunk_s[k]),
      .cout     (co_s[k]),
      .c_msb_in (cm_s[k])
    );
  end

  // Next-state: merge each new chunk into the partial sum and derive the final flags.
  always_comb begin
    vld_d[0] = in_valid && advance_s;
    s_d[0]   = '0;
    s_d[0][CHUNK-1:0] = chunk_s[0];
    for (int k = 1; k < STAGES; k++) begin
      vld_d[k] = vld_q[k-1];
      s_d[k]   = s_q[k-1];
      s_d[k][k*CHUNK +: CHUNK] = chunk_s[k];
    end
    flags_d.c = co_s[STAGES-1];
    flags_d.v = cm_s[STAGES-1] ^ co_s[STAGES-1];
    flags_d.z = (s_d[STAGES-1] == '0);
  end

  // Valid chain and flags: reset, then shift only when the pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      flags_q <= '0;
    end else if (advance_s) begin
      vld_q   <= vld_d;
      flags_q <= flags_d;
    end
  end

  // Datapath registers need no reset; they move together with the valid chain.
  always_ff @(posedge clk) begin
    if (advance_s) begin
      a_q[0] <= A;
      b_q[0] <= beff_s;
      for (int k = 1; k < STAGES; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      c_q <= co_s;
      s_q <= s_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign S         = out_valid ? s_q[STAGES-1] : '0;
  assign C         = out_valid & flags_q.c;
  assign V         = out_valid & flags_q.v;
  assign Z         = out_valid & flags_q.z;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Scoreboard bench: drives the same stimulus into 8/4, 32/1 and 32/8 instances of pipe_add_sub.
module tb_pipe_add_sub;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a_in, b_in;
  logic        ci, sub;
  logic [2:0]  ir, ov, c_o, v_o, z_o;
  logic [31:0] s_o [3];

  exp_t        fifo [3][64];
  int          wr [3];
  int          rd [3];
  int          cyc;
  int          n_checks;
  int          n_pass;
  logic        dir_en;
  exp_t        dir_exp;
  logic        lat_chk;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W  = (g == 0) ? 8 : 32;
    localparam int ST = (g == 0) ? 4 : ((g == 1) ? 1 : 8);
    logic [W-1:0] s_w;
    pipe_add_sub #(.WIDTH(W), .STAGES(ST)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .A         (a_in[W-1:0]),
      .B         (b_in[W-1:0]),
      .CI        (ci),
      .SUB       (sub),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .S         (s_w),
      .C         (c_o[g]),
      .V         (v_o[g]),
      .Z         (z_o[g])
    );
    assign s_o[g] = 32'(s_w);
  end

  function automatic int width_of(input int g);
    return (g == 0) ? 8 : 32;
  endfunction

  function automatic int stages_of(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 1 : 8);
  endfunction

  // Golden model: plain wide addition, overflow from operand/result sign bits.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic c_in, input logic s_in);
    exp_t        r;
    logic [63:0] mask, aa, bb, full;
    mask  = (64'd1 << w) - 64'd1;
    aa    = {32'd0, a} & mask;
    bb    = (s_in ? ~{32'd0, b} : {32'd0, b}) & mask;
    full  = aa + bb + {63'd0, c_in ^ s_in};
    r.s   = 32'(full & mask);
    r.c   = full[w];
    r.v   = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    r.z   = ((full & mask) == 64'd0);
    r.cyc = 32'd0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Per-cycle scoreboard work, done at the falling edge before the handshake edge.
  task automatic monitor();
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        rd[g] = wr[g];
      end else begin
        if (ov[g]) begin
          if (rd[g] == wr[g]) begin
            check($sformatf("d%0d spurious_out", g), 64'd1, 64'd0);
          end else begin
            e = fifo[g][rd[g] % 64];
            check($sformatf("d%0d S", g), 64'(s_o[g]), 64'(e.s));
            check($sformatf("d%0d CVZ", g), 64'({c_o[g], v_o[g], z_o[g]}), 64'({e.c, e.v, e.z}));
            if (out_ready) begin
              if (lat_chk) check($sformatf("d%0d latency", g), 64'(cyc - int'(e.cyc)), 64'(stages_of(g)));
              rd[g]++;
            end
          end
        end
        if (in_valid && ir[g]) begin
          e = (g == 0 && dir_en) ? dir_exp : model(width_of(g), a_in, b_in, ci, sub);
          e.cyc = 32'(cyc);
          fifo[g][wr[g] % 64] = e;
          wr[g]++;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    ci   = c;
    sub  = s;
    step();
  endtask

  task automatic drive_dir(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                           input logic [7:0] es, input logic ec, input logic ev, input logic ez);
    dir_en  = 1'b1;
    dir_exp = '{s: {24'd0, es}, c: ec, v: ev, z: ez, cyc: 32'd0};
    drive(a, b, c, s);
    dir_en  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic check_drained(input string tag);
    for (int g = 0; g < 3; g++) check($sformatf("d%0d %s", g, tag), 64'(rd[g]), 64'(wr[g]));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_in = 32'd0; b_in = 32'd0; ci = 1'b0; sub = 1'b0;
    dir_en = 1'b0; dir_exp = '0; lat_chk = 1'b1;
    cyc = 0; n_checks = 0; n_pass = 0;
    for (int g = 0; g < 3; g++) begin wr[g] = 0; rd[g] = 0; end

    @(posedge clk); #1;
    step();
    step();
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("d%0d reset out_valid", g), 64'(ov[g]), 64'd0);
      check($sformatf("d%0d reset S", g), 64'(s_o[g]), 64'd0);
      check($sformatf("d%0d reset CVZ", g), 64'({c_o[g], v_o[g], z_o[g]}), 64'd0);
      check($sformatf("d%0d reset in_ready", g), 64'(ir[g]), 64'd1);
    end

    // Directed arithmetic corners (expected 8-bit results written out by hand).
    drive_dir(32'hFF, 32'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(6);
    drive_dir(32'h7F, 32'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    drive_dir(32'h05, 32'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    drive_dir(32'h80, 32'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    idle(10);
    check_drained("directed_drained");

    // Back-to-back random ops, full throughput.
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < 3; g++) check($sformatf("d%0d b2b in_ready", g), 64'(ir[g]), 64'd1);
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(12);
    check_drained("b2b_drained");

    // Fill the pipe with out_ready low, stall, then release.
    lat_chk = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 5; i++) begin
      check("d0 stall in_ready", 64'(ir[0]), 64'd0);
      check("d0 stall out_valid", 64'(ov[0]), 64'd1);
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(12);
    check_drained("stall_drained");

    // Reset in the middle of three in-flight ops.
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("d%0d midrst out_valid", g), 64'(ov[g]), 64'd0);
      check($sformatf("d%0d midrst in_ready", g), 64'(ir[g]), 64'd1);
    end
    idle(10);
    drive_dir(32'h0A, 32'h0B, 1'b1, 1'b0, 8'h16, 1'b0, 1'b0, 1'b0);
    idle(10);
    check_drained("final_drained");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
